// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / command consumer and the receive FIFO.
// The master side is the producer/consumer pair; the slave side is the FIFO itself.
interface uart_rx_fifo_if #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
);
   logic              wr;
   logic [DBIT-1:0]   w_data;
   logic              rd;
   logic              clr_ovf;
   logic [DBIT-1:0]   r_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output wr, w_data, rd, clr_ovf,
      input  r_data, empty, full, count, overflow
   );

   modport slave (
      input  wr, w_data, rd, clr_ovf,
      output r_data, empty, full, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO that buffers received UART bytes until the
// command interface pops them; flags are registered and overflow is sticky.
module uart_rx_fifo #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_fifo_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [DBIT-1:0]   mem_d [DEPTH];
   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] rp_q, rp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              overflow_q, overflow_d;
   logic              wr_ok;
   logic              rd_ok;

   // A pop in the same cycle frees a slot, so a write at full is still taken.
   always_comb begin
      wr_ok      = bus.wr & (~full_q | bus.rd);
      rd_ok      = bus.rd & ~empty_q;
      mem_d      = mem_q;
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (wr_ok) begin
         mem_d[wp_q] = bus.w_data;
         wp_d        = wp_q + ADDR_W'(1);
      end
      if (rd_ok) begin
         rp_d = rp_q + ADDR_W'(1);
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (ADDR_W+1)'(1);
         2'b01:   count_d = count_q - (ADDR_W+1)'(1);
         default: count_d = count_q;
      endcase

      if (bus.clr_ovf) begin
         overflow_d = 1'b0;
      end
      if (bus.wr & ~wr_ok) begin
         overflow_d = 1'b1;
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == FULL_CNT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; stale contents are hidden by the empty mask.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.r_data   = empty_q ? '0 : mem_q[rp_q];
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO between the UART receiver and the receive-side command interface. It captures every received byte on the receiver's `rx_done_tick` pulse and holds it until the consumer pops it. This stops back-to-back frames (A, B, OP) from being lost while the consumer is busy. It presents first-word-fall-through (FWFT) read data, registered status flags and a sticky overflow indication.

## Interface
- `DBIT`, 8, data width in bits (matches the UART data bits)
- `ADDR_W`, 4, address width; depth = 2^ADDR_W = 16 entries

- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `wr`  in  1  write strobe, one-cycle pulse (driven by `rx_done_tick`)
- `w_data`  in  DBIT  byte to store; sampled on a `clk` edge where `wr`=1
- `rd`  in  1  pop strobe; removes the head entry
- `clr_ovf`  in  1  synchronous clear of `overflow`
- `r_data`  out  DBIT  head entry (FWFT); forced to 0 while `empty`=1
- `empty`  out  1  no entries stored
- `full`  out  1  2^ADDR_W entries stored
- `count`  out  ADDR_W+1  number of stored entries, 0..2^ADDR_W
- `overflow`  out  1  sticky; set when a write is dropped because the FIFO is full

## Operation
- Storage: 2^ADDR_W x DBIT register array.
- Pointers: write pointer `wp` and read pointer `rp`, each ADDR_W bits, wrapping modulo 2^ADDR_W. There is no extra wrap bit; `count` disambiguates full from empty.
- `count` is registered. `empty` = (`count`==0) and `full` = (`count`==2^ADDR_W), both registered and updated on the same edge as `count`.
- Write accepted = `wr` & (~`full` | `rd`). On an accepted write: mem[`wp`] <= `w_data`, `wp` <= `wp`+1.
- Read accepted = `rd` & ~`empty`. On an accepted read: `rp` <= `rp`+1.
- `count` update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Write while full with no accepted read: the byte is dropped, `wp` and `count` are unchanged, and `overflow` <= 1.
- `rd` while empty: ignored, with no pointer or flag change.
- `wr` and `rd` together while empty: the write is accepted, the read is ignored, and `count` becomes 1.
- `wr` and `rd` together while full: both are accepted, `count` stays at 2^ADDR_W, the head advances and the new byte enters the freed slot.
- `clr_ovf`=1 clears `overflow` on the next edge. If a dropped write happens on the same edge, the set wins and `overflow` stays 1.
- `r_data` = mem[`rp`] when `empty`=0, otherwise 0. It is combinational from registered state, so it never glitches from inputs.
- Asynchronous reset (`reset`=0): `wp`=0, `rp`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `r_data`=0. Memory contents are not reset. A reset mid-stream discards all stored entries immediately, without waiting for a clock edge.

## Timing
- Write-to-read latency is 1 cycle. After the edge that accepts a write into an empty FIFO, `empty` is 0 and `r_data` shows the byte during the following cycle.
- Pop is seen on the next cycle. After the edge that accepts `rd`, `r_data` shows the next entry, or 0 with `empty`=1 if the FIFO is now empty.
- The consumer may hold `rd`=1 continuously and drain one byte per cycle.
- A `wr` pulse longer than one cycle writes once per cycle it is high. The upstream receiver must therefore guarantee single-cycle `rx_done_tick`.
- All flag changes happen only on the `clk` rising edge, except reset.
- `reset` release: the first active edge is the first edge after `reset` returns to 1. Release is assumed synchronous to `clk` at the system level.

## Test plan
- Reset and empty read: assert `reset`=0 mid-operation, then pulse `rd` -> `empty`=1, `count`=0, `r_data`=0, `overflow`=0, and nothing changes on `rd`.
- Single byte: `wr` with `w_data`=0xA5 -> next cycle `empty`=0, `count`=1, `r_data`=0xA5. Then `rd` -> next cycle `empty`=1, `r_data`=0.
- Order and wrap: write 0x00..0x0F (16 bytes) -> `full`=1, `count`=16. Pop 8, write 0x10..0x17, pop all -> order out is 0x00..0x17 with no gaps. Pointers wrap correctly.
- Overflow: from full, `wr` with 0xEE and no `rd` -> `overflow`=1, `count`=16, and 0xEE is never read. Then `clr_ovf` -> `overflow`=0.
- Simultaneous events: at full, `wr`=0x55 and `rd` together -> `count`=16, `overflow`=0, and 0x55 is read last. At empty, `wr`=0x33 and `rd` together -> `count`=1, `r_data`=0x33.
- Streaming: 3 writes (0x01, 0x02, 0x03, as A, B, OP) spaced 160 cycles apart, while the consumer holds `rd` for one cycle each time `empty`=0 -> the consumer receives 0x01, 0x02, 0x03 and `count` returns to 0.
